// File: rtl/sdram_frame_buf_mgr.sv
// sdram_frame_buf_mgr: assigns SDRAM frame banks to the camera write port and
// the display read port. Two banks run as lock-step ping-pong; three or more
// banks decouple the sides, dropping the oldest completed frame on the writer
// side and repeating the last frame on the reader side.
module sdram_frame_buf_mgr #(
    parameter int NUM_BANKS   = 3,
    parameter int BANK_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FEND_POL    = 0,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_valid,
    input  logic              wr_done,
    input  logic              rd_done,
    input  logic              rd_frame_req,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic              wr_load,
    output logic              rd_load,
    output logic              ready_vld,
    output logic              frame_drop,
    output logic              frame_repeat,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  repeat_cnt
);

    typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_RUN, ST_COMMIT} state_t;

    localparam logic [BANK_W-1:0] RD_RST  = BANK_W'(NUM_BANKS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   fv_prev_reg;
    logic                   fend;

    state_t                 wr_state_reg, wr_state_next;
    state_t                 rd_state_reg, rd_state_next;
    logic [BANK_W-1:0]      wr_bank_reg, wr_bank_next;
    logic [BANK_W-1:0]      rd_bank_reg, rd_bank_next;
    logic [BANK_W-1:0]      ready_bank_reg, ready_bank_next;
    logic                   ready_vld_reg, ready_vld_next;
    logic                   drop_reg, drop_next;
    logic                   repeat_reg, repeat_next;
    logic [CNT_W-1:0]       drop_cnt_reg, repeat_cnt_reg;
    logic                   wr_commit;
    logic                   rd_req;

    // Lowest bank index that is neither a nor b.
    function automatic logic [BANK_W-1:0] pick_free(input logic [BANK_W-1:0] a,
                                                    input logic [BANK_W-1:0] b);
        logic [BANK_W-1:0] r;
        r = '0;
        for (int i = NUM_BANKS - 1; i >= 0; i--) begin
            if (BANK_W'(i) != a && BANK_W'(i) != b) r = BANK_W'(i);
        end
        return r;
    endfunction

    // Synchronise the camera frame-active signal and keep one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            fv_prev_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], frame_valid};
            fv_prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign fend = (FEND_POL != 0) ? (sync_reg[SYNC_STAGES-1] & ~fv_prev_reg)
                                  : (~sync_reg[SYNC_STAGES-1] & fv_prev_reg);

    // A commit happens when the writer sees its frame end with the FIFO flushed.
    assign wr_commit = ((wr_state_reg == ST_RUN) && fend && wr_done) ||
                       ((wr_state_reg == ST_COMMIT) && wr_done);
    assign rd_req    = (rd_state_reg == ST_RUN) && rd_frame_req && rd_done;

    // Next-state logic for both FSMs and the shared bank bookkeeping.
    always_comb begin
        wr_state_next   = wr_state_reg;
        rd_state_next   = rd_state_reg;
        wr_bank_next    = wr_bank_reg;
        rd_bank_next    = rd_bank_reg;
        ready_bank_next = ready_bank_reg;
        ready_vld_next  = ready_vld_reg;
        drop_next       = 1'b0;
        repeat_next     = 1'b0;

        case (wr_state_reg)
            ST_INIT:   wr_state_next = ST_LOAD;
            ST_LOAD:   wr_state_next = ST_RUN;
            ST_RUN:    if (fend) wr_state_next = wr_done ? ST_LOAD : ST_COMMIT;
            ST_COMMIT: begin
                // A new frame ended before the previous one finished flushing.
                if (fend) drop_next = 1'b1;
                if (wr_done) wr_state_next = ST_LOAD;
            end
            default:   wr_state_next = ST_INIT;
        endcase

        case (rd_state_reg)
            ST_INIT: rd_state_next = ST_LOAD;
            ST_LOAD: rd_state_next = ST_RUN;
            ST_RUN:  rd_state_next = ST_RUN;
            default: rd_state_next = ST_INIT;
        endcase

        if (NUM_BANKS >= 3) begin
            // Reader is resolved first so a same-cycle commit sees the taken slot.
            if (rd_req) begin
                if (ready_vld_reg) begin
                    rd_bank_next   = ready_bank_reg;
                    ready_vld_next = 1'b0;
                end else begin
                    repeat_next = 1'b1;
                end
                rd_state_next = ST_LOAD;
            end
            if (wr_commit) begin
                if (ready_vld_reg && !rd_req) drop_next = 1'b1;
                ready_bank_next = wr_bank_reg;
                ready_vld_next  = 1'b1;
                wr_bank_next    = pick_free(rd_bank_next, wr_bank_reg);
            end
        end else begin
            // Ping-pong: a commit is only possible while the reader is idle.
            if (wr_commit) begin
                if (rd_done) begin
                    wr_bank_next  = rd_bank_reg;
                    rd_bank_next  = wr_bank_reg;
                    rd_state_next = ST_LOAD;
                end else begin
                    drop_next = 1'b1;
                end
            end
            if (rd_req && !(wr_commit && rd_done)) begin
                repeat_next   = 1'b1;
                rd_state_next = ST_LOAD;
            end
        end
    end

    // State, bank and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_reg   <= ST_INIT;
            rd_state_reg   <= ST_INIT;
            wr_bank_reg    <= '0;
            rd_bank_reg    <= RD_RST;
            ready_bank_reg <= '0;
            ready_vld_reg  <= 1'b0;
            drop_reg       <= 1'b0;
            repeat_reg     <= 1'b0;
        end else begin
            wr_state_reg   <= wr_state_next;
            rd_state_reg   <= rd_state_next;
            wr_bank_reg    <= wr_bank_next;
            rd_bank_reg    <= rd_bank_next;
            ready_bank_reg <= ready_bank_next;
            ready_vld_reg  <= ready_vld_next;
            drop_reg       <= drop_next;
            repeat_reg     <= repeat_next;
        end
    end

    // Saturating statistics counters, updated on the same edge as their pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg   <= '0;
            repeat_cnt_reg <= '0;
        end else begin
            if (drop_next && drop_cnt_reg != CNT_MAX)
                drop_cnt_reg <= drop_cnt_reg + CNT_W'(1);
            if (repeat_next && repeat_cnt_reg != CNT_MAX)
                repeat_cnt_reg <= repeat_cnt_reg + CNT_W'(1);
        end
    end

    assign wr_bank      = wr_bank_reg;
    assign rd_bank      = rd_bank_reg;
    assign wr_load      = (wr_state_reg == ST_LOAD);
    assign rd_load      = (rd_state_reg == ST_LOAD);
    assign ready_vld    = ready_vld_reg;
    assign frame_drop   = drop_reg;
    assign frame_repeat = repeat_reg;
    assign drop_cnt     = drop_cnt_reg;
    assign repeat_cnt   = repeat_cnt_reg;

endmodule

// File: tb/tb_sdram_frame_buf_mgr.sv
// Bench for sdram_frame_buf_mgr: a 3-bank instance and a 2-bank instance with
// narrow counters, driven by directed and random frame transactions and
// compared against a transaction-level model of the bank policies.
module tb_sdram_frame_buf_mgr;

    localparam int S     = 2;
    localparam int MAX2  = 7;
    localparam int MAX3  = 65535;

    logic clk, rst_n;

    logic        fv3, wd3, rdd3, req3;
    logic [1:0]  wb3, rb3;
    logic        wl3, rl3, vld3, fd3, fr3;
    logic [15:0] dc3, rc3;

    logic        fv2, wd2, rdd2, req2;
    logic [1:0]  wb2, rb2;
    logic        wl2, rl2, vld2, fd2, fr2;
    logic [2:0]  dc2, rc2;

    int checks = 0;
    int errors = 0;

    // Pulse totals observed on the outputs.
    int p3_wl = 0, p3_rl = 0, p3_dp = 0, p3_rp = 0;
    int p2_wl = 0, p2_rl = 0, p2_dp = 0, p2_rp = 0;

    // Transaction-level model.
    logic [1:0] m3_wr, m3_rd, m3_ready;
    logic       m3_vld;
    int         m3_drop, m3_rep;
    int         m3_wl = 0, m3_rl = 0, m3_dp = 0, m3_rp = 0;
    logic [1:0] m2_wr, m2_rd;
    int         m2_drop, m2_rep;
    int         m2_wl = 0, m2_rl = 0, m2_dp = 0, m2_rp = 0;

    sdram_frame_buf_mgr #(.NUM_BANKS(3), .BANK_W(2), .SYNC_STAGES(S), .FEND_POL(0), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .frame_valid(fv3), .wr_done(wd3), .rd_done(rdd3),
        .rd_frame_req(req3), .wr_bank(wb3), .rd_bank(rb3), .wr_load(wl3), .rd_load(rl3),
        .ready_vld(vld3), .frame_drop(fd3), .frame_repeat(fr3), .drop_cnt(dc3), .repeat_cnt(rc3));

    sdram_frame_buf_mgr #(.NUM_BANKS(2), .BANK_W(2), .SYNC_STAGES(S), .FEND_POL(0), .CNT_W(3)) u2 (
        .clk(clk), .rst_n(rst_n), .frame_valid(fv2), .wr_done(wd2), .rd_done(rdd2),
        .rd_frame_req(req2), .wr_bank(wb2), .rd_bank(rb2), .wr_load(wl2), .rd_load(rl2),
        .ready_vld(vld2), .frame_drop(fd2), .frame_repeat(fr2), .drop_cnt(dc2), .repeat_cnt(rc2));

    always #5 clk = ~clk;

    // Pulse accounting and bank-exclusion invariant, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            p3_wl += int'(wl3); p3_rl += int'(rl3); p3_dp += int'(fd3); p3_rp += int'(fr3);
            p2_wl += int'(wl2); p2_rl += int'(rl2); p2_dp += int'(fd2); p2_rp += int'(fr2);
            checks++;
            if (wb3 === rb3 || wb2 === rb2) begin
                errors++;
                $display("FAIL invariant: wr3=%0d rd3=%0d wr2=%0d rd2=%0d, required distinct", wb3, rb3, wb2, rb2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- model ----------------
    task automatic mdl3_reset();
        m3_wr = 2'd0; m3_rd = 2'd2; m3_ready = 2'd0; m3_vld = 1'b0;
        m3_drop = 0; m3_rep = 0; m3_wl++; m3_rl++;
    endtask

    task automatic mdl2_reset();
        m2_wr = 2'd0; m2_rd = 2'd1; m2_drop = 0; m2_rep = 0; m2_wl++; m2_rl++;
    endtask

    task automatic mdl3_drop();
        m3_dp++;
        if (m3_drop < MAX3) m3_drop++;
    endtask

    task automatic mdl3_read(input logic done);
        if (done) begin
            if (m3_vld) begin
                m3_rd = m3_ready; m3_vld = 1'b0;
            end else begin
                m3_rp++;
                if (m3_rep < MAX3) m3_rep++;
            end
            m3_rl++;
        end
    endtask

    // Commit after any same-cycle read has been applied.
    task automatic mdl3_commit();
        logic [1:0] old_wr;
        bit found;
        old_wr = m3_wr;
        found = 0;
        if (m3_vld) mdl3_drop();
        m3_ready = old_wr; m3_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!found && 2'(i) != m3_rd && 2'(i) != old_wr) begin
                m3_wr = 2'(i); found = 1;
            end
        end
        m3_wl++;
    endtask

    task automatic mdl2_fend(input logic done);
        logic [1:0] t;
        if (done) begin
            t = m2_wr; m2_wr = m2_rd; m2_rd = t; m2_rl++;
        end else begin
            m2_dp++;
            if (m2_drop < MAX2) m2_drop++;
        end
        m2_wl++;
    endtask

    task automatic mdl2_req(input logic done);
        if (done) begin
            m2_rp++; m2_rl++;
            if (m2_rep < MAX2) m2_rep++;
        end
    endtask

    // ---------------- stimulus drivers ----------------
    task automatic do_fend3(input logic wd, input logic extra);
        fv3 = 1'b1; wd3 = wd; tick(4);
        fv3 = 1'b0; tick(S + 3);
        if (!wd) begin
            if (extra) begin
                fv3 = 1'b1; tick(4); fv3 = 1'b0; tick(S + 3);
            end
            wd3 = 1'b1; tick(1); wd3 = 1'b0; tick(3);
        end
        wd3 = 1'b0;
    endtask

    task automatic do_req3(input logic done);
        rdd3 = done; req3 = 1'b1; tick(1);
        req3 = 1'b0; rdd3 = 1'b0; tick(3);
    endtask

    task automatic do_sim3();
        fv3 = 1'b1; wd3 = 1'b0; tick(4);
        fv3 = 1'b0; tick(S + 3);
        wd3 = 1'b1; req3 = 1'b1; rdd3 = 1'b1; tick(1);
        wd3 = 1'b0; req3 = 1'b0; rdd3 = 1'b0; tick(3);
    endtask

    task automatic do_fend2(input logic done);
        rdd2 = done; wd2 = 1'b1; fv2 = 1'b1; tick(4);
        fv2 = 1'b0; tick(S + 3);
        rdd2 = 1'b0; wd2 = 1'b0;
    endtask

    task automatic do_req2(input logic done);
        rdd2 = done; req2 = 1'b1; tick(1);
        req2 = 1'b0; rdd2 = 1'b0; tick(3);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; tick(3);
        checks++;
        if ({wb3, rb3, vld3, wl3, rl3, fd3, fr3, dc3, rc3} !== {2'd0, 2'd2, 5'b0, 32'd0}) begin
            errors++;
            $display("FAIL rst3: got wr=%0d rd=%0d vld=%0d wl=%0d rl=%0d dc=%0d rc=%0d, required 0 2 0 0 0 0 0",
                     wb3, rb3, vld3, wl3, rl3, dc3, rc3);
        end
        checks++;
        if ({wb2, rb2, vld2, wl2, rl2, fd2, fr2, dc2, rc2} !== {2'd0, 2'd1, 5'b0, 6'd0}) begin
            errors++;
            $display("FAIL rst2: got wr=%0d rd=%0d vld=%0d dc=%0d rc=%0d, required 0 1 0 0 0", wb2, rb2, vld2, dc2, rc2);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({wl3, rl3, wl2, rl2} !== 4'b0000) begin
            errors++;
            $display("FAIL load_pre: got %b, required 0000", {wl3, rl3, wl2, rl2});
        end
        tick(1);
        checks++;
        if ({wl3, rl3, wl2, rl2} !== 4'b1111) begin
            errors++;
            $display("FAIL load_pulse: got %b, required 1111", {wl3, rl3, wl2, rl2});
        end
        tick(1);
        checks++;
        if ({wl3, rl3, wl2, rl2} !== 4'b0000) begin
            errors++;
            $display("FAIL load_end: got %b, required 0000", {wl3, rl3, wl2, rl2});
        end
        mdl3_reset(); mdl2_reset();
        tick(2);
        $display("txn reset: wr3=%0d rd3=%0d wr2=%0d rd2=%0d", wb3, rb3, wb2, rb2);
    endtask

    task automatic test_commit_read();
        fv3 = 1'b1; wd3 = 1'b1; tick(4);
        fv3 = 1'b0; tick(S);
        checks++;
        if ({wl3, vld3} !== 2'b00) begin
            errors++;
            $display("FAIL fend_early: got wl=%0d vld=%0d, required 0 0", wl3, vld3);
        end
        tick(1);
        checks++;
        if ({wb3, rb3, vld3, wl3} !== {2'd1, 2'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL fend_commit: got wr=%0d rd=%0d vld=%0d wl=%0d, required 1 2 1 1", wb3, rb3, vld3, wl3);
        end
        tick(1);
        checks++;
        if (wl3 !== 1'b0) begin
            errors++;
            $display("FAIL wl_end: got %0d, required 0", wl3);
        end
        mdl3_commit();
        tick(3); wd3 = 1'b0;
        do_req3(1'b1); mdl3_read(1'b1);
        checks++;
        if ({rb3, vld3, wb3} !== {2'd0, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL read_ready: got rd=%0d vld=%0d wr=%0d, required 0 0 1", rb3, vld3, wb3);
        end
        checks++;
        if (p3_rl !== m3_rl || p3_wl !== m3_wl) begin
            errors++;
            $display("FAIL cr_pulses: got wl=%0d rl=%0d, required %0d %0d", p3_wl, p3_rl, m3_wl, m3_rl);
        end
        $display("txn commit_read: wr=%0d rd=%0d vld=%0d", wb3, rb3, vld3);
    endtask

    task automatic test_repeat();
        do_req3(1'b1); mdl3_read(1'b1);
        checks++;
        if ({rb3, rc3, vld3} !== {m3_rd, 16'd1, 1'b0} || p3_rp !== m3_rp || p3_rl !== m3_rl) begin
            errors++;
            $display("FAIL repeat: got rd=%0d rc=%0d rp=%0d rl=%0d, required %0d 1 %0d %0d",
                     rb3, rc3, p3_rp, p3_rl, m3_rd, m3_rp, m3_rl);
        end
        do_req3(1'b0); mdl3_read(1'b0);
        checks++;
        if ({rb3, rc3} !== {m3_rd, 16'(m3_rep)} || p3_rl !== m3_rl) begin
            errors++;
            $display("FAIL ignored_req: got rd=%0d rc=%0d rl=%0d, required %0d %0d %0d", rb3, rc3, p3_rl, m3_rd, m3_rep, m3_rl);
        end
        $display("txn repeat: rd=%0d repeat_cnt=%0d", rb3, rc3);
    endtask

    task automatic test_drop();
        do_fend3(1'b1, 1'b0); mdl3_commit();
        do_fend3(1'b1, 1'b0); mdl3_commit();
        checks++;
        if ({wb3, rb3, vld3, dc3} !== {m3_wr, m3_rd, m3_vld, 16'd1} || p3_dp !== 1) begin
            errors++;
            $display("FAIL drop: got wr=%0d rd=%0d vld=%0d dc=%0d dp=%0d, required %0d %0d %0d 1 1",
                     wb3, rb3, vld3, dc3, p3_dp, m3_wr, m3_rd, m3_vld);
        end
        // Reading back exposes which bank was left holding the ready frame.
        do_req3(1'b1); mdl3_read(1'b1);
        checks++;
        if ({rb3, vld3} !== {m3_rd, 1'b0}) begin
            errors++;
            $display("FAIL drop_ready: got rd=%0d vld=%0d, required %0d 0", rb3, vld3, m3_rd);
        end
        $display("txn drop: wr=%0d rd=%0d drop_cnt=%0d", wb3, rb3, dc3);
    endtask

    task automatic test_simultaneous();
        int dp0;
        do_fend3(1'b1, 1'b0); mdl3_commit();
        dp0 = p3_dp;
        do_sim3(); mdl3_read(1'b1); mdl3_commit();
        checks++;
        if ({wb3, rb3, vld3, dc3, rc3} !== {m3_wr, m3_rd, m3_vld, 16'(m3_drop), 16'(m3_rep)} || p3_dp !== dp0) begin
            errors++;
            $display("FAIL simultaneous: got wr=%0d rd=%0d vld=%0d dp=%0d, required %0d %0d %0d %0d",
                     wb3, rb3, vld3, p3_dp, m3_wr, m3_rd, m3_vld, dp0);
        end
        // The reader took the ready bank; the next read must find the just-committed one.
        do_req3(1'b1); mdl3_read(1'b1);
        checks++;
        if ({rb3, vld3} !== {m3_rd, 1'b0}) begin
            errors++;
            $display("FAIL sim_follow: got rd=%0d vld=%0d, required %0d 0", rb3, vld3, m3_rd);
        end
        $display("txn simultaneous: wr=%0d rd=%0d vld=%0d", wb3, rb3, vld3);
    endtask

    task automatic test_random3();
        int k;
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(0, 5));
            case (k)
                0: begin do_fend3(1'b1, 1'b0); mdl3_commit(); end
                1: begin do_fend3(1'b0, 1'b0); mdl3_commit(); end
                2: begin do_fend3(1'b0, 1'b1); mdl3_drop(); mdl3_commit(); end
                3: begin do_req3(1'b1); mdl3_read(1'b1); end
                4: begin do_req3(1'b0); mdl3_read(1'b0); end
                default: begin do_sim3(); mdl3_read(1'b1); mdl3_commit(); end
            endcase
            checks++;
            if ({wb3, rb3, vld3, dc3, rc3} !== {m3_wr, m3_rd, m3_vld, 16'(m3_drop), 16'(m3_rep)}) begin
                errors++;
                $display("FAIL rand3_state it=%0d kind=%0d: got wr=%0d rd=%0d vld=%0d dc=%0d rc=%0d, required %0d %0d %0d %0d %0d",
                         it, k, wb3, rb3, vld3, dc3, rc3, m3_wr, m3_rd, m3_vld, m3_drop, m3_rep);
            end
            checks++;
            if (p3_wl !== m3_wl || p3_rl !== m3_rl || p3_dp !== m3_dp || p3_rp !== m3_rp) begin
                errors++;
                $display("FAIL rand3_pulses it=%0d: got wl=%0d rl=%0d dp=%0d rp=%0d, required %0d %0d %0d %0d",
                         it, p3_wl, p3_rl, p3_dp, p3_rp, m3_wl, m3_rl, m3_dp, m3_rp);
            end
            $display("txn rand3 %0d kind=%0d wr=%0d rd=%0d vld=%0d", it, k, wb3, rb3, vld3);
        end
    endtask

    task automatic test_pingpong();
        do_fend2(1'b0); mdl2_fend(1'b0);
        checks++;
        if ({wb2, rb2, dc2} !== {2'd0, 2'd1, 3'd1} || p2_wl !== m2_wl || p2_rl !== m2_rl) begin
            errors++;
            $display("FAIL pp_drop: got wr=%0d rd=%0d dc=%0d wl=%0d rl=%0d, required 0 1 1 %0d %0d",
                     wb2, rb2, dc2, p2_wl, p2_rl, m2_wl, m2_rl);
        end
        do_fend2(1'b1); mdl2_fend(1'b1);
        checks++;
        if ({wb2, rb2, dc2} !== {2'd1, 2'd0, 3'd1} || p2_wl !== m2_wl || p2_rl !== m2_rl) begin
            errors++;
            $display("FAIL pp_swap: got wr=%0d rd=%0d dc=%0d wl=%0d rl=%0d, required 1 0 1 %0d %0d",
                     wb2, rb2, dc2, p2_wl, p2_rl, m2_wl, m2_rl);
        end
        $display("txn pingpong: wr=%0d rd=%0d", wb2, rb2);
    endtask

    task automatic test_random2();
        int k;
        for (int it = 0; it < 20; it++) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0: begin do_fend2(1'b0); mdl2_fend(1'b0); end
                1: begin do_fend2(1'b1); mdl2_fend(1'b1); end
                2: begin do_req2(1'b1); mdl2_req(1'b1); end
                default: begin do_req2(1'b0); mdl2_req(1'b0); end
            endcase
            checks++;
            if ({wb2, rb2, vld2, dc2, rc2} !== {m2_wr, m2_rd, 1'b0, 3'(m2_drop), 3'(m2_rep)} ||
                p2_wl !== m2_wl || p2_rl !== m2_rl || p2_dp !== m2_dp || p2_rp !== m2_rp) begin
                errors++;
                $display("FAIL rand2 it=%0d kind=%0d: got wr=%0d rd=%0d dc=%0d rc=%0d wl=%0d rl=%0d, required %0d %0d %0d %0d %0d %0d",
                         it, k, wb2, rb2, dc2, rc2, p2_wl, p2_rl, m2_wr, m2_rd, m2_drop, m2_rep, m2_wl, m2_rl);
            end
            $display("txn rand2 %0d kind=%0d wr=%0d rd=%0d", it, k, wb2, rb2);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 9; i++) begin
            do_fend2(1'b0); mdl2_fend(1'b0);
        end
        checks++;
        if (dc2 !== 3'(m2_drop) || dc2 !== 3'd7 || p2_dp !== m2_dp) begin
            errors++;
            $display("FAIL saturate: got dc=%0d dp=%0d, required 7 %0d", dc2, p2_dp, m2_dp);
        end
        $display("txn saturation: drop_cnt=%0d", dc2);
    endtask

    task automatic test_mid_reset();
        do_fend3(1'b1, 1'b0); mdl3_commit();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({wb3, rb3, vld3, dc3, rc3, wb2, rb2, dc2, rc2} !== {2'd0, 2'd2, 1'b0, 32'd0, 2'd0, 2'd1, 6'd0}) begin
            errors++;
            $display("FAIL mid_reset: got wr3=%0d rd3=%0d vld3=%0d dc3=%0d rc3=%0d wr2=%0d rd2=%0d dc2=%0d, required 0 2 0 0 0 0 1 0",
                     wb3, rb3, vld3, dc3, rc3, wb2, rb2, dc2);
        end
        tick(2);
        rst_n = 1'b1;
        mdl3_reset(); mdl2_reset();
        tick(3);
        checks++;
        if (p3_wl !== m3_wl || p3_rl !== m3_rl || p2_wl !== m2_wl || p2_rl !== m2_rl) begin
            errors++;
            $display("FAIL reload: got wl3=%0d rl3=%0d wl2=%0d rl2=%0d, required %0d %0d %0d %0d",
                     p3_wl, p3_rl, p2_wl, p2_rl, m3_wl, m3_rl, m2_wl, m2_rl);
        end
        do_fend3(1'b1, 1'b0); mdl3_commit();
        checks++;
        if ({wb3, rb3, vld3} !== {m3_wr, m3_rd, m3_vld}) begin
            errors++;
            $display("FAIL post_reset: got wr=%0d rd=%0d vld=%0d, required %0d %0d %0d", wb3, rb3, vld3, m3_wr, m3_rd, m3_vld);
        end
        $display("txn mid_reset: wr=%0d rd=%0d vld=%0d", wb3, rb3, vld3);
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        fv3 = 1'b0; wd3 = 1'b0; rdd3 = 1'b0; req3 = 1'b0;
        fv2 = 1'b0; wd2 = 1'b0; rdd2 = 1'b0; req2 = 1'b0;
        test_reset();
        test_commit_read();
        test_repeat();
        test_drop();
        test_simultaneous();
        test_random3();
        test_pingpong();
        test_random2();
        test_saturation();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
